// File: rtl/io_bus_initiator.sv
// io_bus_initiator: converts upstream read/write requests (reads may burst)
// into single-cycle register-bus accesses and returns one response beat per
// access. Decode errors end a burst early and are tallied in a saturating
// counter.
module io_bus_initiator #(
    parameter int unsigned CLenW = 4
) (
    input  logic             AClkH,
    input  logic             AResetH,
    input  logic             AClkHEn,
    input  logic             AReqValid,
    output logic             AReqReady,
    input  logic             AReqRnW,
    input  logic [1:0]       AReqSize,
    input  logic [15:0]      AReqAddr,
    input  logic [CLenW-1:0] AReqLen,
    input  logic [63:0]      AReqWrData,
    output logic             ARspValid,
    input  logic             ARspReady,
    output logic [63:0]      ARspData,
    output logic [1:0]       ARspErr,
    output logic             ARspLast,
    output logic [15:0]      AIoAddr,
    output logic [63:0]      AIoMosi,
    output logic [3:0]       AIoWrSize,
    output logic [3:0]       AIoRdSize,
    input  logic [63:0]      AIoMiso,
    input  logic             AIoAddrAck,
    input  logic             AIoAddrErr,
    output logic [7:0]       AErrCnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             rnw;
    logic [1:0]       size;
    logic [15:0]      addr;
    logic [CLenW-1:0] cnt;
    logic [63:0]      wrdata;
    logic [1:0]       rsp_err;
    logic [63:0]      rsp_data;
    logic [7:0]       err_cnt;
    logic [1:0]       err_now;
    logic [63:0]      size_mask;
    logic [63:0]      data_now;
    logic             rsp_last;

    // Classify the current bus access and size-mask its read data.
    always_comb begin
        err_now   = 2'b00;
        size_mask = '1;
        data_now  = '0;
        if (AIoAddrErr) begin
            err_now = 2'b01;
        end else if (!AIoAddrAck) begin
            err_now = 2'b10;
        end
        case (size)
            2'd0:    size_mask = 64'h0000_0000_0000_00FF;
            2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = '1;
        endcase
        if (rnw && (err_now == 2'b00)) begin
            data_now = AIoMiso & size_mask;
        end
    end

    // Next-state logic and bus/handshake outputs.
    always_comb begin
        state_next = state;
        AReqReady  = (state == IDLE);
        ARspValid  = (state == RESP);
        rsp_last   = (state == RESP) && ((cnt == '0) || (rsp_err != 2'b00));
        ARspLast   = rsp_last;
        ARspData   = rsp_data;
        ARspErr    = rsp_err;
        AErrCnt    = err_cnt;
        AIoAddr    = '0;
        AIoMosi    = '0;
        AIoWrSize  = '0;
        AIoRdSize  = '0;
        if (state == ACCESS) begin
            AIoAddr = addr;
            AIoMosi = wrdata;
            // Strobes only on edges that will actually sample the result.
            if (AClkHEn && !AResetH) begin
                if (rnw) begin
                    AIoRdSize = 4'b0001 << size;
                end else begin
                    AIoWrSize = 4'b0001 << size;
                end
            end
        end
        case (state)
            IDLE:    if (AReqValid) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    if (ARspReady) state_next = rsp_last ? IDLE : ACCESS;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset overrides the clock enable.
    always_ff @(posedge AClkH) begin
        if (AResetH) begin
            state <= IDLE;
        end else if (AClkHEn) begin
            state <= state_next;
        end
    end

    // Request latch, response capture, burst stepping and error counting.
    always_ff @(posedge AClkH) begin
        if (AResetH) begin
            rnw      <= 1'b0;
            size     <= 2'd0;
            addr     <= '0;
            cnt      <= '0;
            wrdata   <= '0;
            rsp_err  <= 2'b00;
            rsp_data <= '0;
            err_cnt  <= '0;
        end else if (AClkHEn) begin
            case (state)
                IDLE: begin
                    if (AReqValid) begin
                        rnw    <= AReqRnW;
                        size   <= AReqSize;
                        addr   <= AReqAddr;
                        cnt    <= AReqRnW ? AReqLen : '0;
                        wrdata <= AReqWrData;
                    end
                end
                ACCESS: begin
                    rsp_err  <= err_now;
                    rsp_data <= data_now;
                    if ((err_now != 2'b00) && (err_cnt != 8'hFF)) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (ARspReady && !rsp_last) begin
                        addr <= addr + 16'd1;
                        cnt  <= cnt - CLenW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_initiator.sv
// Directed testbench for io_bus_initiator with a small responder model.
module tb_io_bus_initiator;

    logic        clk = 1'b0;
    logic        AResetH, AClkHEn, AReqValid, AReqReady, AReqRnW;
    logic [1:0]  AReqSize;
    logic [15:0] AReqAddr;
    logic [3:0]  AReqLen;
    logic [63:0] AReqWrData;
    logic        ARspValid, ARspReady, ARspLast;
    logic [63:0] ARspData;
    logic [1:0]  ARspErr;
    logic [15:0] AIoAddr;
    logic [63:0] AIoMosi, AIoMiso;
    logic [3:0]  AIoWrSize, AIoRdSize;
    logic        AIoAddrAck, AIoAddrErr;
    logic [7:0]  AErrCnt;

    // Responder model controls
    logic        ack_en, err_en;
    logic [15:0] err_addr;
    logic [63:0] miso_val;
    logic        strobe_any;

    int checks = 0;
    int passes = 0;
    int strobe_cnt = 0;
    int valid_cnt = 0;

    always #5 clk = ~clk;

    io_bus_initiator #(.CLenW(4)) dut (
        .AClkH(clk), .AResetH(AResetH), .AClkHEn(AClkHEn),
        .AReqValid(AReqValid), .AReqReady(AReqReady), .AReqRnW(AReqRnW),
        .AReqSize(AReqSize), .AReqAddr(AReqAddr), .AReqLen(AReqLen),
        .AReqWrData(AReqWrData), .ARspValid(ARspValid), .ARspReady(ARspReady),
        .ARspData(ARspData), .ARspErr(ARspErr), .ARspLast(ARspLast),
        .AIoAddr(AIoAddr), .AIoMosi(AIoMosi), .AIoWrSize(AIoWrSize),
        .AIoRdSize(AIoRdSize), .AIoMiso(AIoMiso), .AIoAddrAck(AIoAddrAck),
        .AIoAddrErr(AIoAddrErr), .AErrCnt(AErrCnt)
    );

    assign strobe_any = |(AIoRdSize | AIoWrSize);
    assign AIoAddrAck = ack_en & strobe_any;
    assign AIoAddrErr = err_en & strobe_any & (AIoAddr == err_addr);
    assign AIoMiso    = (|AIoRdSize) ? miso_val : 64'h0;

    // Count strobe cycles and response-valid cycles mid-cycle.
    always @(negedge clk) begin
        if (strobe_any) strobe_cnt++;
        if (ARspValid) valid_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rnw, input logic [1:0] sz, input logic [15:0] a,
                         input logic [3:0] len, input logic [63:0] wd);
        AReqValid = 1'b1; AReqRnW = rnw; AReqSize = sz; AReqAddr = a;
        AReqLen = len; AReqWrData = wd;
        step();
        AReqValid = 1'b0;
    endtask

    task automatic test_reset();
        AResetH = 1'b1; AClkHEn = 1'b0;
        step(); step();
        AResetH = 1'b0; AClkHEn = 1'b1;
        #1;
        checks++; if (AReqReady !== 1'b1) $display("FAIL reset_ready: got %0b want 1", AReqReady); else passes++;
        checks++; if (ARspValid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", ARspValid); else passes++;
        checks++; if (ARspData !== 64'h0) $display("FAIL reset_data: got %h want 0", ARspData); else passes++;
        checks++; if (ARspErr !== 2'b00) $display("FAIL reset_err: got %b want 00", ARspErr); else passes++;
        checks++; if (ARspLast !== 1'b0) $display("FAIL reset_last: got %0b want 0", ARspLast); else passes++;
        checks++; if (AErrCnt !== 8'd0) $display("FAIL reset_errcnt: got %0d want 0", AErrCnt); else passes++;
        checks++; if (AIoAddr !== 16'h0) $display("FAIL reset_ioaddr: got %h want 0", AIoAddr); else passes++;
    endtask

    task automatic test_byte_write();
        int s;
        s = strobe_cnt;
        issue(1'b0, 2'd0, 16'h0010, 4'd5, 64'hA5);
        #1;
        checks++; if (AIoWrSize !== 4'b0001) $display("FAIL bw_wrsize: got %b want 0001", AIoWrSize); else passes++;
        checks++; if (AIoRdSize !== 4'b0000) $display("FAIL bw_rdsize: got %b want 0000", AIoRdSize); else passes++;
        checks++; if (AIoMosi !== 64'hA5) $display("FAIL bw_mosi: got %h want a5", AIoMosi); else passes++;
        checks++; if (AIoAddr !== 16'h0010) $display("FAIL bw_addr: got %h want 0010", AIoAddr); else passes++;
        checks++; if (AReqReady !== 1'b0) $display("FAIL bw_busy: got %0b want 0", AReqReady); else passes++;
        step(); #1;
        checks++; if (ARspValid !== 1'b1) $display("FAIL bw_valid: got %0b want 1", ARspValid); else passes++;
        checks++; if (ARspErr !== 2'b00) $display("FAIL bw_err: got %b want 00", ARspErr); else passes++;
        checks++; if (ARspLast !== 1'b1) $display("FAIL bw_last: got %0b want 1", ARspLast); else passes++;
        checks++; if (ARspData !== 64'h0) $display("FAIL bw_data: got %h want 0", ARspData); else passes++;
        checks++; if (AIoWrSize !== 4'b0000) $display("FAIL bw_strobe_resp: got %b want 0000", AIoWrSize); else passes++;
        ARspReady = 1'b1; step(); ARspReady = 1'b0; #1;
        checks++; if (AReqReady !== 1'b1) $display("FAIL bw_idle: got %0b want 1", AReqReady); else passes++;
        checks++; if (ARspValid !== 1'b0) $display("FAIL bw_done_valid: got %0b want 0", ARspValid); else passes++;
        checks++; if (strobe_cnt - s !== 1) $display("FAIL bw_strobes: got %0d want 1", strobe_cnt - s); else passes++;
    endtask

    task automatic test_word_burst();
        logic [15:0] exp_a [4];
        logic        exp_last;
        int s;
        exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        miso_val = 64'hDEADBEEF_00001234;
        s = strobe_cnt;
        issue(1'b1, 2'd1, 16'hFFFE, 4'd3, 64'h0);
        for (int i = 0; i < 4; i++) begin
            exp_last = (i == 3);
            #1;
            checks++; if (AIoRdSize !== 4'b0010) $display("FAIL wb_rdsize%0d: got %b want 0010", i, AIoRdSize); else passes++;
            checks++; if (AIoAddr !== exp_a[i]) $display("FAIL wb_addr%0d: got %h want %h", i, AIoAddr, exp_a[i]); else passes++;
            step(); #1;
            checks++; if (ARspValid !== 1'b1) $display("FAIL wb_valid%0d: got %0b want 1", i, ARspValid); else passes++;
            checks++; if (ARspData !== 64'h1234) $display("FAIL wb_data%0d: got %h want 1234", i, ARspData); else passes++;
            checks++; if (ARspLast !== exp_last) $display("FAIL wb_last%0d: got %0b want %0b", i, ARspLast, exp_last); else passes++;
            ARspReady = 1'b1; step(); ARspReady = 1'b0;
        end
        #1;
        checks++; if (AReqReady !== 1'b1) $display("FAIL wb_idle: got %0b want 1", AReqReady); else passes++;
        checks++; if (strobe_cnt - s !== 4) $display("FAIL wb_strobes: got %0d want 4", strobe_cnt - s); else passes++;
    endtask

    task automatic test_err_burst();
        int s;
        err_en = 1'b1; err_addr = 16'h0101;
        s = strobe_cnt;
        issue(1'b1, 2'd2, 16'h0100, 4'd3, 64'h0);
        #1;
        checks++; if (AIoRdSize !== 4'b0100) $display("FAIL eb_rdsize: got %b want 0100", AIoRdSize); else passes++;
        step(); #1;
        checks++; if (ARspData !== 64'h0000_1234) $display("FAIL eb_data0: got %h want 1234", ARspData); else passes++;
        checks++; if (ARspErr !== 2'b00) $display("FAIL eb_err0: got %b want 00", ARspErr); else passes++;
        checks++; if (ARspLast !== 1'b0) $display("FAIL eb_last0: got %0b want 0", ARspLast); else passes++;
        ARspReady = 1'b1; step(); ARspReady = 1'b0; #1;
        checks++; if (AIoAddr !== 16'h0101) $display("FAIL eb_addr1: got %h want 0101", AIoAddr); else passes++;
        step(); #1;
        checks++; if (ARspErr !== 2'b01) $display("FAIL eb_err1: got %b want 01", ARspErr); else passes++;
        checks++; if (ARspLast !== 1'b1) $display("FAIL eb_last1: got %0b want 1", ARspLast); else passes++;
        checks++; if (ARspData !== 64'h0) $display("FAIL eb_data1: got %h want 0", ARspData); else passes++;
        checks++; if (AErrCnt !== 8'd1) $display("FAIL eb_errcnt: got %0d want 1", AErrCnt); else passes++;
        ARspReady = 1'b1; step(); ARspReady = 1'b0;
        step(); step(); #1;
        checks++; if (strobe_cnt - s !== 2) $display("FAIL eb_strobes: got %0d want 2", strobe_cnt - s); else passes++;
        checks++; if (AReqReady !== 1'b1) $display("FAIL eb_idle: got %0b want 1", AReqReady); else passes++;
        err_en = 1'b0;
    endtask

    task automatic test_no_responder();
        int s;
        ack_en = 1'b0;
        issue(1'b1, 2'd2, 16'h2000, 4'd0, 64'h0);
        step(); #1;
        checks++; if (ARspErr !== 2'b10) $display("FAIL nr_err: got %b want 10", ARspErr); else passes++;
        checks++; if (ARspData !== 64'h0) $display("FAIL nr_data: got %h want 0", ARspData); else passes++;
        checks++; if (ARspLast !== 1'b1) $display("FAIL nr_last: got %0b want 1", ARspLast); else passes++;
        checks++; if (AErrCnt !== 8'd2) $display("FAIL nr_errcnt: got %0d want 2", AErrCnt); else passes++;
        s = strobe_cnt;
        for (int i = 0; i < 5; i++) begin
            step(); #1;
            checks++; if (ARspValid !== 1'b1) $display("FAIL nr_hold_valid%0d: got %0b want 1", i, ARspValid); else passes++;
            checks++; if (ARspErr !== 2'b10) $display("FAIL nr_hold_err%0d: got %b want 10", i, ARspErr); else passes++;
        end
        checks++; if (strobe_cnt - s !== 0) $display("FAIL nr_strobes: got %0d want 0", strobe_cnt - s); else passes++;
        ARspReady = 1'b1; step(); ARspReady = 1'b0; #1;
        checks++; if (AReqReady !== 1'b1) $display("FAIL nr_idle: got %0b want 1", AReqReady); else passes++;
        ack_en = 1'b1;
    endtask

    task automatic test_clken_and_reset();
        int s;
        miso_val = 64'h0123_4567_89AB_CDEF;
        issue(1'b1, 2'd3, 16'h3000, 4'd0, 64'h0);
        AClkHEn = 1'b0; #1;
        checks++; if (AIoRdSize !== 4'b0000) $display("FAIL ce_strobe_off: got %b want 0000", AIoRdSize); else passes++;
        checks++; if (AIoAddr !== 16'h3000) $display("FAIL ce_addr: got %h want 3000", AIoAddr); else passes++;
        s = strobe_cnt;
        step(); step(); #1;
        checks++; if (ARspValid !== 1'b0) $display("FAIL ce_frozen_state: got %0b want 0", ARspValid); else passes++;
        checks++; if (strobe_cnt - s !== 0) $display("FAIL ce_strobes: got %0d want 0", strobe_cnt - s); else passes++;
        AClkHEn = 1'b1; #1;
        checks++; if (AIoRdSize !== 4'b1000) $display("FAIL ce_rdsize: got %b want 1000", AIoRdSize); else passes++;
        step(); #1;
        checks++; if (ARspData !== 64'h0123_4567_89AB_CDEF) $display("FAIL ce_data: got %h want 0123456789abcdef", ARspData); else passes++;
        AClkHEn = 1'b0; ARspReady = 1'b1;
        step(); step(); #1;
        checks++; if (ARspValid !== 1'b1) $display("FAIL ce_frozen_resp: got %0b want 1", ARspValid); else passes++;
        ARspReady = 1'b0; AResetH = 1'b1;
        step();
        AResetH = 1'b0; AClkHEn = 1'b1; #1;
        checks++; if (AReqReady !== 1'b1) $display("FAIL rr_ready: got %0b want 1", AReqReady); else passes++;
        checks++; if (ARspValid !== 1'b0) $display("FAIL rr_valid: got %0b want 0", ARspValid); else passes++;
        checks++; if (AErrCnt !== 8'd0) $display("FAIL rr_errcnt: got %0d want 0", AErrCnt); else passes++;
        checks++; if (ARspData !== 64'h0) $display("FAIL rr_data: got %h want 0", ARspData); else passes++;
    endtask

    task automatic test_reset_mid_burst();
        int s, v;
        issue(1'b1, 2'd0, 16'h4000, 4'd3, 64'h0);
        AResetH = 1'b1; #1;
        checks++; if (AIoRdSize !== 4'b0000) $display("FAIL rm_strobe: got %b want 0000", AIoRdSize); else passes++;
        s = strobe_cnt; v = valid_cnt;
        step();
        AResetH = 1'b0;
        step(); step(); step(); step(); #1;
        checks++; if (strobe_cnt - s !== 0) $display("FAIL rm_strobes: got %0d want 0", strobe_cnt - s); else passes++;
        checks++; if (valid_cnt - v !== 0) $display("FAIL rm_valids: got %0d want 0", valid_cnt - v); else passes++;
        checks++; if (AReqReady !== 1'b1) $display("FAIL rm_idle: got %0b want 1", AReqReady); else passes++;
    endtask

    task automatic test_err_saturate();
        ack_en = 1'b0; ARspReady = 1'b1;
        for (int i = 0; i < 255; i++) begin
            issue(1'b0, 2'd0, 16'h0000, 4'd0, 64'h0);
            step(); step();
        end
        #1;
        checks++; if (AErrCnt !== 8'd255) $display("FAIL sat_255: got %0d want 255", AErrCnt); else passes++;
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, 2'd0, 16'h0000, 4'd0, 64'h0);
            step(); step();
        end
        #1;
        checks++; if (AErrCnt !== 8'd255) $display("FAIL sat_hold: got %0d want 255", AErrCnt); else passes++;
        ARspReady = 1'b0; ack_en = 1'b1;
    endtask

    initial begin
        AResetH = 1'b1; AClkHEn = 1'b0; AReqValid = 1'b0; AReqRnW = 1'b0;
        AReqSize = 2'd0; AReqAddr = 16'h0; AReqLen = 4'd0; AReqWrData = 64'h0;
        ARspReady = 1'b0; ack_en = 1'b1; err_en = 1'b0; err_addr = 16'h0;
        miso_val = 64'h0;
        test_reset();
        test_byte_write();
        test_word_burst();
        test_err_burst();
        test_no_responder();
        test_clken_and_reset();
        test_reset_mid_burst();
        test_err_saturate();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
